// File: rtl/seg_mux_driver.sv
// rtl/seg_mux_driver.sv - time-multiplexed N-digit 7-segment display driver
module seg_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0,
    localparam int IDX_W         = $clog2(NUM_DIGITS),
    localparam int PRE_W         = $clog2(REFRESH_DIV)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    logic [PRE_W-1:0]        presc, presc_n;
    logic [IDX_W-1:0]        idx_n;
    logic                    wrap, xfer;
    logic [4*NUM_DIGITS-1:0] act_bcd, act_bcd_n, pend_bcd;
    logic [NUM_DIGITS-1:0]   act_dp, act_dp_n, pend_dp;
    logic                    pend_v;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [3:0]              cur_digit;
    logic [6:0]              seg_raw;
    logic [NUM_DIGITS-1:0]   an_raw;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000001;
        endcase
    endfunction

    // Next-state view: outputs are registered from this so that they line up
    // with the digit_idx/prescaler values visible in the same cycle.
    always_comb begin
        presc_n = presc;
        idx_n   = digit_idx;
        wrap    = 1'b0;
        if (enable) begin
            if (presc == PRE_W'(REFRESH_DIV - 1)) begin
                presc_n = '0;
                wrap    = (digit_idx == IDX_W'(NUM_DIGITS - 1));
                idx_n   = wrap ? '0 : digit_idx + 1'b1;
            end else begin
                presc_n = presc + 1'b1;
            end
        end
        xfer      = wrap && pend_v;
        act_bcd_n = xfer ? pend_bcd : act_bcd;
        act_dp_n  = xfer ? pend_dp : act_dp;
    end

    // upper_zero[i]: digits i..NUM_DIGITS-1 are all zero (invalid codes are non-zero)
    always_comb begin
        upper_zero = '0;
        upper_zero[NUM_DIGITS-1] = (act_bcd_n[4*NUM_DIGITS-1 -: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (act_bcd_n[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        cur_digit = act_bcd_n[{idx_n, 2'b00} +: 4];
        if (blank_lz && (idx_n != '0) && upper_zero[idx_n])
            seg_raw = 7'b0000000;
        else
            seg_raw = decode(cur_digit);
        if (presc_n < PRE_W'(BLANK_CYCLES))
            an_raw = '0;
        else
            an_raw = NUM_DIGITS'(1) << idx_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            digit_idx <= '0;
            act_bcd   <= '0;
            act_dp    <= '0;
            pend_bcd  <= '0;
            pend_dp   <= '0;
            pend_v    <= 1'b0;
        end else begin
            presc     <= presc_n;
            digit_idx <= idx_n;
            act_bcd   <= act_bcd_n;
            act_dp    <= act_dp_n;
            // A load in the wrap cycle refills pending after the transfer.
            if (load) begin
                pend_bcd <= bcd_in;
                pend_dp  <= dp_in;
                pend_v   <= 1'b1;
            end else if (xfer) begin
                pend_v   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            seg        <= {7{SEG_ACTIVE_LOW}};
            dp         <= SEG_ACTIVE_LOW;
            an         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_raw ^ {7{SEG_ACTIVE_LOW}};
            dp         <= act_dp_n[idx_n] ^ SEG_ACTIVE_LOW;
            an         <= an_raw ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_mux_driver.sv
// tb/tb_seg_mux_driver.sv - randomized model-checked bench for seg_mux_driver
module tb_seg_mux_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        enable = 1'b0;
    logic [6:0]  seg, seg2;
    logic        dp, dp2, frame_done, fd2;
    logic [3:0]  an, an2;
    logic [1:0]  digit_idx, idx2;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state: enabled-cycle count since reset drives the scan
    int          m_tick;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_adp, m_pdp;
    logic        m_pv;
    logic [29:0] exp_v;
    wire  [29:0] got_v = {seg, dp, an, digit_idx, frame_done, seg2, dp2, an2, idx2, fd2};

    seg_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
                     .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .enable(enable), .seg(seg), .dp(dp), .an(an),
        .digit_idx(digit_idx), .frame_done(frame_done));

    seg_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
                     .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .enable(enable), .seg(seg2), .dp(dp2), .an(an2),
        .digit_idx(idx2), .frame_done(fd2));

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1111110;  1: return 7'b0110000;
            2: return 7'b1101101;  3: return 7'b1111001;
            4: return 7'b0110011;  5: return 7'b1011011;
            6: return 7'b1011111;  7: return 7'b1110000;
            8: return 7'b1111111;  9: return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    // advance one clock and update the model from the inputs sampled at that edge
    task automatic tick();
        logic       en_s, wrap;
        int         idx;
        logic [6:0] e_seg;
        logic       e_dp, e_fd;
        logic [3:0] e_an;
        @(posedge clk);
        en_s = enable;
        wrap = 1'b0;
        e_seg = '0; e_dp = 1'b0; e_an = '0; e_fd = 1'b0;
        if (rst) begin
            m_tick = 0; m_act = '0; m_adp = '0; m_pv = 1'b0;
        end else begin
            if (en_s) begin
                m_tick++;
                wrap = ((m_tick % 32) == 0);
            end
            if (wrap && m_pv) begin
                m_act = m_pend; m_adp = m_pdp; m_pv = 1'b0;
            end
            if (load) begin
                m_pend = bcd_in; m_pdp = dp_in; m_pv = 1'b1;
            end
        end
        idx = (m_tick / 8) % 4;
        if (!rst && en_s) begin
            if (blank_lz && idx > 0 && (m_act >> (4 * idx)) == 16'd0)
                e_seg = 7'b0000000;
            else
                e_seg = ref_seg(int'((m_act >> (4 * idx)) & 16'hF));
            e_dp = m_adp[idx];
            e_an = ((m_tick % 8) < 2) ? 4'b0000 : (4'b0001 << idx);
            e_fd = wrap;
        end
        exp_v = {e_seg, e_dp, e_an, 2'(idx), e_fd, ~e_seg, ~e_dp, ~e_an, 2'(idx), e_fd};
        #1;
    endtask

    function automatic string fmt();
        return $sformatf("got seg=%b dp=%b an=%b idx=%0d fd=%b | inv seg=%b dp=%b an=%b; expected %b_%b_%b_%0d_%b | %b_%b_%b",
            got_v[29:23], got_v[22], got_v[21:18], got_v[17:16], got_v[15],
            got_v[14:8], got_v[7], got_v[6:3],
            exp_v[29:23], exp_v[22], exp_v[21:18], exp_v[17:16], exp_v[15],
            exp_v[14:8], exp_v[7], exp_v[6:3]);
    endfunction

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL reset t=%0t %s", $time, fmt()); end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan_zero();
        enable = 1'b1;
        for (int i = 0; i < 70; i++) begin
            tick();
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL scan_zero t=%0t %s", $time, fmt()); end
        end
    endtask

    task automatic test_load_mid_frame();
        bcd_in = 16'h1234; dp_in = 4'b0100; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 72; i++) begin
            tick();
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL load_mid_frame t=%0t %s", $time, fmt()); end
        end
    endtask

    task automatic test_leading_zero();
        bcd_in = 16'h0070; dp_in = 4'b0000; load = 1'b1; blank_lz = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 64) blank_lz = 1'b0;
            tick();
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL leading_zero t=%0t %s", $time, fmt()); end
        end
    endtask

    task automatic test_invalid_and_wrap_load();
        int guard;
        bcd_in = 16'h00AF; dp_in = 4'b0001; load = 1'b1; blank_lz = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL invalid_codes t=%0t %s", $time, fmt()); end
        end
        guard = 0;
        while ((m_tick % 32) != 31 && guard < 40) begin
            tick();
            guard++;
        end
        n_checks++;
        if ((m_tick % 32) != 31) begin
            n_fail++; $display("FAIL wrap_search got tick=%0d expected phase 31", m_tick);
        end
        bcd_in = 16'h8888; dp_in = 4'b1010; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL wrap_cycle_load t=%0t %s", $time, fmt()); end
        end
    endtask

    task automatic test_enable_hold();
        for (int i = 0; i < 45; i++) begin
            enable = !(i >= 20 && i < 40);
            tick();
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL enable_hold t=%0t %s", $time, fmt()); end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        bcd_in = 16'h5555; dp_in = 4'b1111; load = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL reset_mid_frame t=%0t %s", $time, fmt()); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            enable   = ($urandom_range(0, 7) != 0);
            blank_lz = ($urandom_range(0, 1) == 1);
            load     = ($urandom_range(0, 15) == 0);
            bcd_in   = 16'($urandom);
            dp_in    = 4'($urandom);
            tick();
            n_checks++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL random t=%0t %s", $time, fmt()); end
        end
        load = 1'b0;
    endtask

    initial begin
        m_tick = 0; m_act = '0; m_adp = '0; m_pend = '0; m_pdp = '0; m_pv = 1'b0;
        exp_v = '0;
        test_reset();
        test_scan_zero();
        test_load_mid_frame();
        test_leading_zero();
        test_invalid_and_wrap_load();
        test_enable_hold();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
